mdu_rvs: RTL and testbench
==========================

Name: mdu_rvs

Overview:
- Reservation station feeding the multiply/divide unit; it drives the issue side of the rvs-to-exu handshake, with the MDU as responder.
- Accepts dispatched MDU micro-ops with operands that are either values or pending tags.
- Snoops the CDB to wake pending operands.
- Issues fully-ready entries to the MDU over a req/rdy handshake, one per cycle at most.

Parameters:
TAG_W, 4, width of ROB/physical tag carried on dispatch, CDB and issue
DEPTH, 4, number of station entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries (branch mispredict)
disp_vld  in  1  dispatch request
disp_rdy  out  1  at least one free entry
disp_opc  in  3  mdu op (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
disp_tag  in  TAG_W  destination tag
disp_src1_rdy  in  1  src1 value valid
disp_src1  in  32  src1 value (meaningful when disp_src1_rdy)
disp_src1_tag  in  TAG_W  producer tag of src1 (meaningful when not ready)
disp_src2_rdy  in  1  src2 value valid
disp_src2  in  32  src2 value (meaningful when disp_src2_rdy)
disp_src2_tag  in  TAG_W  producer tag of src2 (meaningful when not ready)
cdb_vld  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB broadcast tag
cdb_wdata  in  32  CDB broadcast data
iss_req  out  1  issue request to MDU (rvs2exu req)
iss_rdy  in  1  MDU ready (rvs2exu rdy)
iss_opc  out  3  issued opcode
iss_src1  out  32  issued src1
iss_src2  out  32  issued src2
iss_tag  out  TAG_W  issued destination tag

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset: all entry valid bits clear.
  - disp_rdy=1, iss_req=0.
  - iss_opc/src/tag = 0 while no entry is selected.
- Entry state: valid, opc, tag, src1/src2 value, src1/src2 ready, src1/src2 tag.
- Dispatch:
  - Accepted on disp_vld && disp_rdy.
  - Written into the lowest-index free entry at the clock edge.
  - disp_rdy is combinational: it reflects free entries at the start of the cycle. A slot freed by an issue in the same cycle is not reusable that cycle.
- Dispatch bypass: if a dispatched operand is not ready and cdb_vld && cdb_tag equals its tag in the same cycle, the entry stores cdb_wdata and marks that operand ready.
- Wakeup: each cycle, every valid entry with a non-ready operand whose tag equals cdb_tag (cdb_vld=1) captures cdb_wdata and sets ready at the edge. Both operands may wake on one broadcast.
- Select:
  - Candidate = valid && src1 ready && src2 ready.
  - iss_req = any candidate.
  - The chosen entry is the lowest-index candidate.
  - iss_* outputs are combinational from the chosen entry.
- Issue: on iss_req && iss_rdy the chosen entry's valid clears at the edge.
  - Without iss_rdy, selection is re-evaluated each cycle. A lower-index entry becoming ready may displace the current choice; the MDU samples only on req&&rdy.
- Latency:
  - Dispatch with both operands ready: iss_req no earlier than the next cycle.
  - Entry woken at cycle N: may issue at N+1.
  - Nothing issues in the cycle it is dispatched or woken.
- Full: disp_rdy=0 when all DEPTH entries are valid; disp_vld is ignored.
- Empty: iss_req=0.
- flush: all valid bits clear at the edge; a dispatch in the same cycle is dropped.
  - iss_req is still driven combinationally that cycle. A handshake completing in the flush cycle is legal; the MDU result is discarded downstream.
- Reset mid-operation: identical to flush plus output defaults. Pending wakeups are lost.
- Opcode is opaque; there are no width or sign transformations.

Decomposition:
- mdu_op encoding (3-bit mdu_op_*) stays in rv32i_types. Add an rvs_entry_t struct typedef there, parameterised via TAG_W, with localparam usage.
- One natural sub-module: rvs_prio_enc (lowest-index one-hot/index priority encoder, width DEPTH), instantiated twice: free-slot pick and issue select.

Test Plan:
- Ready dispatch: opc=mul, src1=7, src2=6, both ready, tag=3, iss_rdy=1 -> iss_req=1 next cycle with src1=7, src2=6, tag=3; entry freed; disp_rdy stays 1.
- Wakeup: dispatch div with src2 pending on tag 5. Two cycles later CDB tag=5, data=0x10 -> iss_req rises the following cycle with iss_src2=0x10.
- Bypass: dispatch with src1 pending on tag 2 while cdb_vld=1, tag=2, data=0xAB in the same cycle -> next cycle iss_req=1, iss_src1=0xAB.
- Full/backpressure: iss_rdy=0, dispatch 4 ready ops tags 1..4 -> disp_rdy=0 after the 4th; 5th disp_vld is ignored. Raise iss_rdy -> issue order tags 1,2,3,4 on consecutive cycles.
- Select priority: entry0 pending, entry1 ready, iss_rdy=0 -> iss_tag=entry1. Wake entry0 -> iss_tag switches to entry0 the next cycle.
- Flush: 3 entries valid, assert flush with a concurrent dispatch -> next cycle iss_req=0, disp_rdy=1, and no later issue of any flushed tag.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - MDU opcode encoding and reservation-station entry type
package rv32i_types;

   typedef enum logic [2:0] {
      MDU_OP_MUL    = 3'd0,
      MDU_OP_MULH   = 3'd1,
      MDU_OP_MULHSU = 3'd2,
      MDU_OP_MULHU  = 3'd3,
      MDU_OP_DIV    = 3'd4,
      MDU_OP_DIVU   = 3'd5,
      MDU_OP_REM    = 3'd6,
      MDU_OP_REMU   = 3'd7
   } mdu_op_e;

   localparam int RVS_TAG_W = 4;

   typedef struct packed {
      logic                 vld;
      logic [2:0]           opc;
      logic [RVS_TAG_W-1:0] tag;
      logic                 s1_rdy;
      logic [31:0]          s1;
      logic [RVS_TAG_W-1:0] s1_tag;
      logic                 s2_rdy;
      logic [31:0]          s2;
      logic [RVS_TAG_W-1:0] s2_tag;
   } rvs_entry_t;

endpackage

// File: rtl/rvs_prio_enc.sv
// rtl/rvs_prio_enc.sv - lowest-index priority encoder returning index and any-set flag
module rvs_prio_enc #(
   parameter int W = 4
) (
   input  logic [W-1:0]         req,
   output logic                 vld,
   output logic [$clog2(W)-1:0] idx
);

   localparam int IW = $clog2(W);

   always_comb begin
      vld = |req;
      idx = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = W - 1; i >= 0; i--) begin
         if (req[i]) idx = i[IW-1:0];
      end
   end

endmodule

// File: rtl/mdu_rvs.sv
// rtl/mdu_rvs.sv - MDU reservation station: dispatch, CDB wakeup, lowest-index issue select
module mdu_rvs
   import rv32i_types::*;
#(
   parameter int TAG_W = RVS_TAG_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             disp_vld,
   output logic             disp_rdy,
   input  logic [2:0]       disp_opc,
   input  logic [TAG_W-1:0] disp_tag,
   input  logic             disp_src1_rdy,
   input  logic [31:0]      disp_src1,
   input  logic [TAG_W-1:0] disp_src1_tag,
   input  logic             disp_src2_rdy,
   input  logic [31:0]      disp_src2,
   input  logic [TAG_W-1:0] disp_src2_tag,
   input  logic             cdb_vld,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_wdata,
   output logic             iss_req,
   input  logic             iss_rdy,
   output logic [2:0]       iss_opc,
   output logic [31:0]      iss_src1,
   output logic [31:0]      iss_src2,
   output logic [TAG_W-1:0] iss_tag
);

   localparam int IDX_W = $clog2(DEPTH);

   rvs_entry_t       ent_q [DEPTH];
   rvs_entry_t       ent_d [DEPTH];
   logic [DEPTH-1:0] free_vec;
   logic [DEPTH-1:0] cand_vec;
   logic             free_vld;
   logic             sel_vld;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] sel_idx;
   logic             disp_fire;
   logic             iss_fire;
   logic             byp1;
   logic             byp2;

   always_comb begin
      free_vec = '0;
      cand_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         free_vec[i] = !ent_q[i].vld;
         cand_vec[i] = ent_q[i].vld && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
      end
   end

   rvs_prio_enc #(.W(DEPTH)) u_free_enc (.req(free_vec), .vld(free_vld), .idx(free_idx));
   rvs_prio_enc #(.W(DEPTH)) u_sel_enc  (.req(cand_vec), .vld(sel_vld),  .idx(sel_idx));

   assign disp_rdy  = free_vld;
   assign iss_req   = sel_vld;
   assign disp_fire = disp_vld && free_vld;
   assign iss_fire  = sel_vld && iss_rdy;
   assign byp1      = cdb_vld && !disp_src1_rdy && (disp_src1_tag == cdb_tag);
   assign byp2      = cdb_vld && !disp_src2_rdy && (disp_src2_tag == cdb_tag);

   always_comb begin
      iss_opc  = '0;
      iss_src1 = '0;
      iss_src2 = '0;
      iss_tag  = '0;
      if (sel_vld) begin
         iss_opc  = ent_q[sel_idx].opc;
         iss_src1 = ent_q[sel_idx].s1;
         iss_src2 = ent_q[sel_idx].s2;
         iss_tag  = ent_q[sel_idx].tag;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (cdb_vld && ent_q[i].vld) begin
            if (!ent_q[i].s1_rdy && ent_q[i].s1_tag == cdb_tag) begin
               ent_d[i].s1_rdy = 1'b1;
               ent_d[i].s1     = cdb_wdata;
            end
            if (!ent_q[i].s2_rdy && ent_q[i].s2_tag == cdb_tag) begin
               ent_d[i].s2_rdy = 1'b1;
               ent_d[i].s2     = cdb_wdata;
            end
         end
      end
      if (iss_fire) ent_d[sel_idx].vld = 1'b0;
      // The free slot comes from start-of-cycle state, so it never collides with the issuing entry.
      if (disp_fire) begin
         ent_d[free_idx].vld    = 1'b1;
         ent_d[free_idx].opc    = disp_opc;
         ent_d[free_idx].tag    = disp_tag;
         ent_d[free_idx].s1_rdy = disp_src1_rdy || byp1;
         ent_d[free_idx].s1     = byp1 ? cdb_wdata : disp_src1;
         ent_d[free_idx].s1_tag = disp_src1_tag;
         ent_d[free_idx].s2_rdy = disp_src2_rdy || byp2;
         ent_d[free_idx].s2     = byp2 ? cdb_wdata : disp_src2;
         ent_d[free_idx].s2_tag = disp_src2_tag;
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].vld = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) ent_q[i] <= '0;
         else     ent_q[i] <= ent_d[i];
      end
   end

endmodule

// File: tb/tb_mdu_rvs.sv
// tb/tb_mdu_rvs.sv - directed and randomized checks of mdu_rvs against an entry-list model
module tb_mdu_rvs;
   import rv32i_types::*;

   localparam int TAG_W = 4;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst, flush, disp_vld, disp_rdy;
   logic [2:0]       disp_opc;
   logic [TAG_W-1:0] disp_tag, disp_src1_tag, disp_src2_tag;
   logic             disp_src1_rdy, disp_src2_rdy;
   logic [31:0]      disp_src1, disp_src2;
   logic             cdb_vld;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_wdata;
   logic             iss_req, iss_rdy;
   logic [2:0]       iss_opc;
   logic [31:0]      iss_src1, iss_src2;
   logic [TAG_W-1:0] iss_tag;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: a list of DEPTH slots holding the dispatched micro-ops and operand state.
   bit       m_vld [DEPTH];
   int       m_opc [DEPTH], m_tag [DEPTH], m_t1 [DEPTH], m_t2 [DEPTH];
   bit       m_r1 [DEPTH], m_r2 [DEPTH];
   int       m_v1 [DEPTH], m_v2 [DEPTH];

   mdu_rvs #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_opc(disp_opc), .disp_tag(disp_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src1(disp_src1), .disp_src1_tag(disp_src1_tag),
      .disp_src2_rdy(disp_src2_rdy), .disp_src2(disp_src2), .disp_src2_tag(disp_src2_tag),
      .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
      .iss_req(iss_req), .iss_rdy(iss_rdy), .iss_opc(iss_opc),
      .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_tag(iss_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic int first_free();
      for (int i = 0; i < DEPTH; i++) if (!m_vld[i]) return i;
      return -1;
   endfunction

   function automatic int first_ready();
      for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_r1[i] && m_r2[i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      int s, f;
      s = first_ready();
      f = first_free();
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
         return;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (m_vld[i] && cdb_vld) begin
            if (!m_r1[i] && m_t1[i] == int'(cdb_tag)) begin m_r1[i] = 1; m_v1[i] = int'(cdb_wdata); end
            if (!m_r2[i] && m_t2[i] == int'(cdb_tag)) begin m_r2[i] = 1; m_v2[i] = int'(cdb_wdata); end
         end
      end
      if (s >= 0 && iss_rdy) m_vld[s] = 0;
      if (disp_vld && f >= 0) begin
         m_vld[f] = 1;
         m_opc[f] = int'(disp_opc);
         m_tag[f] = int'(disp_tag);
         m_t1[f]  = int'(disp_src1_tag);
         m_t2[f]  = int'(disp_src2_tag);
         m_r1[f]  = disp_src1_rdy || (cdb_vld && disp_src1_tag == cdb_tag);
         m_r2[f]  = disp_src2_rdy || (cdb_vld && disp_src2_tag == cdb_tag);
         m_v1[f]  = disp_src1_rdy ? int'(disp_src1) : (m_r1[f] ? int'(cdb_wdata) : 0);
         m_v2[f]  = disp_src2_rdy ? int'(disp_src2) : (m_r2[f] ? int'(cdb_wdata) : 0);
      end
   endtask

   task automatic model_check();
      int s;
      s = first_ready();
      chk("rnd_disp_rdy", 32'(disp_rdy), 32'(first_free() >= 0));
      chk("rnd_iss_req",  32'(iss_req),  32'(s >= 0));
      chk("rnd_iss_opc",  32'(iss_opc),  (s >= 0) ? 32'(m_opc[s]) : 32'd0);
      chk("rnd_iss_src1", iss_src1,      (s >= 0) ? 32'(m_v1[s])  : 32'd0);
      chk("rnd_iss_src2", iss_src2,      (s >= 0) ? 32'(m_v2[s])  : 32'd0);
      chk("rnd_iss_tag",  32'(iss_tag),  (s >= 0) ? 32'(m_tag[s]) : 32'd0);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_vld = 0; cdb_vld = 0; flush = 0; rst = 0;
   endtask

   task automatic disp(input int opc, input int tag, input bit r1, input int v1, input int t1,
                       input bit r2, input int v2, input int t2);
      disp_vld = 1; disp_opc = 3'(opc); disp_tag = TAG_W'(tag);
      disp_src1_rdy = r1; disp_src1 = 32'(v1); disp_src1_tag = TAG_W'(t1);
      disp_src2_rdy = r2; disp_src2 = 32'(v2); disp_src2_tag = TAG_W'(t2);
   endtask

   task automatic cdb(input int tag, input int data);
      cdb_vld = 1; cdb_tag = TAG_W'(tag); cdb_wdata = 32'(data);
   endtask

   initial begin
      idle();
      disp_opc = '0; disp_tag = '0; disp_src1_rdy = 0; disp_src1 = '0; disp_src1_tag = '0;
      disp_src2_rdy = 0; disp_src2 = '0; disp_src2_tag = '0; cdb_tag = '0; cdb_wdata = '0;
      iss_rdy = 0;
      rst = 1;
      cycle(); cycle();
      idle();
      chk("rst_disp_rdy", 32'(disp_rdy), 32'd1);
      chk("rst_iss_req",  32'(iss_req),  32'd0);
      chk("rst_iss_opc",  32'(iss_opc),  32'd0);
      chk("rst_iss_src1", iss_src1,      32'd0);
      chk("rst_iss_tag",  32'(iss_tag),  32'd0);

      // Ready dispatch: issues the cycle after dispatch, not the same cycle.
      iss_rdy = 1;
      disp(MDU_OP_MUL, 3, 1, 7, 0, 1, 6, 0);
      chk("rdy_same_cycle_req", 32'(iss_req), 32'd0);
      cycle(); idle();
      chk("rdy_req",  32'(iss_req),  32'd1);
      chk("rdy_src1", iss_src1,      32'd7);
      chk("rdy_src2", iss_src2,      32'd6);
      chk("rdy_tag",  32'(iss_tag),  32'd3);
      chk("rdy_opc",  32'(iss_opc),  32'(MDU_OP_MUL));
      chk("rdy_disp_rdy", 32'(disp_rdy), 32'd1);
      cycle();
      chk("rdy_freed", 32'(iss_req), 32'd0);

      // Wakeup through the CDB two cycles after dispatch.
      disp(MDU_OP_DIV, 7, 1, 100, 0, 0, 0, 5);
      cycle(); idle();
      chk("wk_wait0", 32'(iss_req), 32'd0);
      cycle();
      chk("wk_wait1", 32'(iss_req), 32'd0);
      cdb(5, 32'h10);
      chk("wk_cdb_cycle", 32'(iss_req), 32'd0);
      cycle(); idle();
      chk("wk_req",  32'(iss_req), 32'd1);
      chk("wk_src2", iss_src2,     32'h10);
      chk("wk_src1", iss_src1,     32'd100);
      chk("wk_tag",  32'(iss_tag), 32'd7);
      cycle();
      chk("wk_freed", 32'(iss_req), 32'd0);

      // Dispatch bypass from a same-cycle broadcast.
      disp(MDU_OP_REM, 8, 0, 0, 2, 1, 3, 0);
      cdb(2, 32'hAB);
      cycle(); idle();
      chk("byp_req",  32'(iss_req), 32'd1);
      chk("byp_src1", iss_src1,     32'hAB);
      chk("byp_src2", iss_src2,     32'd3);
      cycle();

      // Fill under backpressure, drop an extra dispatch, drain in order.
      iss_rdy = 0;
      for (int k = 1; k <= 4; k++) begin
         disp(MDU_OP_MULHU, k, 1, k, 0, 1, 0, 0);
         cycle();
      end
      chk("full_disp_rdy", 32'(disp_rdy), 32'd0);
      disp(MDU_OP_MULHU, 9, 1, 9, 0, 1, 0, 0);
      cycle(); idle();
      iss_rdy = 1;
      for (int k = 1; k <= 4; k++) begin
         chk("drain_req", 32'(iss_req), 32'd1);
         chk("drain_tag", 32'(iss_tag), 32'(k));
         cycle();
      end
      chk("drain_empty_req", 32'(iss_req),  32'd0);
      chk("drain_empty_rdy", 32'(disp_rdy), 32'd1);

      // A lower-index entry that wakes displaces the current selection.
      iss_rdy = 0;
      disp(MDU_OP_DIVU, 10, 0, 0, 12, 1, 1, 0);
      cycle();
      disp(MDU_OP_REMU, 11, 1, 2, 0, 1, 3, 0);
      cycle(); idle();
      chk("prio_pick1", 32'(iss_tag), 32'd11);
      cdb(12, 32'h55);
      chk("prio_woken_cycle", 32'(iss_tag), 32'd11);
      cycle(); idle();
      chk("prio_pick0", 32'(iss_tag), 32'd10);
      chk("prio_src1",  iss_src1,     32'h55);
      iss_rdy = 1;
      cycle();
      chk("prio_next", 32'(iss_tag), 32'd11);
      cycle();
      chk("prio_empty", 32'(iss_req), 32'd0);

      // Flush with a concurrent dispatch drops everything.
      iss_rdy = 0;
      for (int k = 13; k <= 15; k++) begin
         disp(MDU_OP_MULH, k, 1, k, 0, 1, k, 0);
         cycle();
      end
      disp(MDU_OP_MUL, 1, 1, 1, 0, 1, 1, 0);
      flush = 1;
      chk("fl_req_in_flush", 32'(iss_req), 32'd1);
      chk("fl_tag_in_flush", 32'(iss_tag), 32'd13);
      cycle(); idle();
      chk("fl_req",      32'(iss_req),  32'd0);
      chk("fl_disp_rdy", 32'(disp_rdy), 32'd1);
      iss_rdy = 1;
      for (int k = 0; k < 3; k++) begin
         chk("fl_no_issue", 32'(iss_req), 32'd0);
         cycle();
      end

      // Randomized traffic against the reference list.
      rst = 1;
      cycle();
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         flush    = ($urandom_range(0, 39) == 0);
         iss_rdy  = ($urandom_range(0, 9) < 6);
         disp(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              bit'($urandom_range(0, 1)), int'($urandom), int'($urandom_range(0, 7)),
              bit'($urandom_range(0, 1)), int'($urandom), int'($urandom_range(0, 7)));
         disp_vld = ($urandom_range(0, 1) == 1);
         cdb_vld  = ($urandom_range(0, 9) < 4);
         cdb_tag  = TAG_W'($urandom_range(0, 7));
         cdb_wdata = $urandom;
         model_check();
         cycle();
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
